bcd_alarm_clock: RTL and testbench

//  Parametrised time-of-day clock: packed BCD HH:MM:SS:CC (CC = hundredths), derived from CLOCK_50.

---
 rtl/clock_pkg.sv | 65 ++++++
 rtl/bcd_seg7.sv | 27 ++
 rtl/bcd_alarm_clock.sv | 248 ++++++++++++++++++++++++
 tb/tb_bcd_alarm_clock.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the BCD alarm clock: field selects, BCD limits,
// active-low seven-segment patterns and the BCD field step/validation helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        SEL_HH = 2'd0,
        SEL_MM = 2'd1,
        SEL_SS = 2'd2,
        SEL_CC = 2'd3
    } field_sel_t;

    localparam logic [7:0] LIM_HH = 8'h23;
    localparam logic [7:0] LIM_MM = 8'h59;
    localparam logic [7:0] LIM_SS = 8'h59;
    localparam logic [7:0] LIM_CC = 8'h99;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       carry;
        logic [7:0] value;
    } bcd_step_t;

    function automatic bcd_step_t bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        bcd_step_t r;
        r.carry = 1'b0;
        r.value = 8'h00;
        if (value >= limit) begin
            r.carry = 1'b1;
            r.value = 8'h00;
        end else if (value[3:0] >= 4'd9) begin
            r.value = {value[7:4] + 4'd1, 4'd0};
        end else begin
            r.value = {value[7:4], value[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] limit);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);
    endfunction

    function automatic logic [7:0] field_limit(input logic [1:0] sel);
        logic [7:0] lim;
        case (sel)
            SEL_HH:  lim = LIM_HH;
            SEL_MM:  lim = LIM_MM;
            SEL_SS:  lim = LIM_SS;
            SEL_CC:  lim = LIM_CC;
            default: lim = 8'h00;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/bcd_seg7.sv
// BCD digit to active-low seven-segment decoder; non-decimal codes blank the digit.
module bcd_seg7
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit pattern lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_alarm_clock.sv
// BCD HH:MM:SS:CC time-of-day clock with settable alarm, timed buzzer and eight HEX drivers.
// Define ALARM_SNOOZE_EN to build the snooze countdown; otherwise alarm_snooze is ignored.
module bcd_alarm_clock
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int ALARM_SECS = 30,
    parameter int SNOOZE_S   = 300
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [7:0]  time_in,
    input  logic [1:0]  set_sel,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    input  logic        alarm_snooze,
    input  logic        show_alarm,
    output logic [31:0] time_bcd,
    output logic [31:0] alarm_bcd,
    output logic        tick,
    output logic        set_err,
    output logic        alarm_sound,
    output logic [6:0]  hex7,
    output logic [6:0]  hex6,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0
);

    localparam int              PRESCALE     = CLK_HZ / TICK_HZ;
    localparam int              PW           = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_TC       = PW'(PRESCALE - 1);
    localparam logic [7:0]      ALARM_SECS_V = 8'(ALARM_SECS);

    logic [PW-1:0] presc_r;
    logic [7:0]    hh_r, mm_r, ss_r, cc_r;
    logic [7:0]    al_hh_r, al_mm_r, al_ss_r, al_cc_r;
    logic          tick_r, sec_tick_r, set_err_r;
    logic          sound_r;
    logic [7:0]    secs_r;
    logic [6:0]    hex_r [8];
    logic [6:0]    seg_s [8];

    logic [7:0]    limit_s;
    logic          wr_ok_s, tc_s, fire_s;
    bcd_step_t     cc_step_s, ss_step_s, mm_step_s, hh_step_s;
    logic [31:0]   disp_s;

    // Write validation, prescaler terminal count and carry chain.
    always_comb begin
        limit_s   = field_limit(set_sel);
        wr_ok_s   = bcd_valid(time_in, limit_s);
        tc_s      = (presc_r == PRE_TC);
        cc_step_s = bcd_inc(cc_r, LIM_CC);
        ss_step_s = bcd_inc(ss_r, LIM_SS);
        mm_step_s = bcd_inc(mm_r, LIM_MM);
        hh_step_s = bcd_inc(hh_r, LIM_HH);
        fire_s    = tick_r && alarm_en &&
                    ({hh_r, mm_r, ss_r, cc_r} == {al_hh_r, al_mm_r, al_ss_r, al_cc_r});
        disp_s    = show_alarm ? {al_hh_r, al_mm_r, al_ss_r, al_cc_r}
                               : {hh_r, mm_r, ss_r, cc_r};
    end

    // Prescaler, time-of-day counter and time-field writes; a valid write drops a coincident tick.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            presc_r    <= '0;
            hh_r       <= 8'h00;
            mm_r       <= 8'h00;
            ss_r       <= 8'h00;
            cc_r       <= 8'h00;
            tick_r     <= 1'b0;
            sec_tick_r <= 1'b0;
            set_err_r  <= 1'b0;
        end else begin
            tick_r     <= 1'b0;
            sec_tick_r <= 1'b0;
            set_err_r  <= (set_time || set_alarm) && !wr_ok_s;
            if (set_time && wr_ok_s) begin
                presc_r <= '0;
                case (set_sel)
                    SEL_HH:  hh_r <= time_in;
                    SEL_MM:  mm_r <= time_in;
                    SEL_SS:  ss_r <= time_in;
                    SEL_CC:  cc_r <= time_in;
                    default: cc_r <= cc_r;
                endcase
            end else if (tc_s) begin
                presc_r    <= '0;
                tick_r     <= 1'b1;
                sec_tick_r <= cc_step_s.carry;
                cc_r       <= cc_step_s.value;
                if (cc_step_s.carry) begin
                    ss_r <= ss_step_s.value;
                    if (ss_step_s.carry) begin
                        mm_r <= mm_step_s.value;
                        if (mm_step_s.carry) begin
                            hh_r <= hh_step_s.value;
                        end else begin
                            hh_r <= hh_r;
                        end
                    end else begin
                        mm_r <= mm_r;
                    end
                end else begin
                    ss_r <= ss_r;
                end
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Alarm setpoint writes.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            al_hh_r <= 8'h00;
            al_mm_r <= 8'h00;
            al_ss_r <= 8'h00;
            al_cc_r <= 8'h00;
        end else if (set_alarm && wr_ok_s) begin
            case (set_sel)
                SEL_HH:  al_hh_r <= time_in;
                SEL_MM:  al_mm_r <= time_in;
                SEL_SS:  al_ss_r <= time_in;
                SEL_CC:  al_cc_r <= time_in;
                default: al_cc_r <= al_cc_r;
            endcase
        end else begin
            al_cc_r <= al_cc_r;
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic        snz_act_r;
    logic [15:0] snz_cnt_r;
    localparam logic [15:0] SNOOZE_V = 16'(SNOOZE_S);
`else
    logic unused_snooze_s;
    assign unused_snooze_s = alarm_snooze ^ SNOOZE_S[0];
`endif

    // Buzzer: enable gate, acknowledge, snooze, fire and per-second timeout, in priority order.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sound_r   <= 1'b0;
            secs_r    <= 8'd0;
`ifdef ALARM_SNOOZE_EN
            snz_act_r <= 1'b0;
            snz_cnt_r <= 16'd0;
`endif
        end else if (!alarm_en) begin
            sound_r   <= 1'b0;
            secs_r    <= 8'd0;
`ifdef ALARM_SNOOZE_EN
            snz_act_r <= 1'b0;
            snz_cnt_r <= 16'd0;
`endif
        end else if (alarm_ack) begin
            sound_r   <= 1'b0;
            secs_r    <= 8'd0;
`ifdef ALARM_SNOOZE_EN
            snz_act_r <= 1'b0;
            snz_cnt_r <= 16'd0;
        end else if (alarm_snooze && sound_r) begin
            sound_r   <= 1'b0;
            secs_r    <= 8'd0;
            snz_act_r <= 1'b1;
            snz_cnt_r <= SNOOZE_V;
`endif
        end else if (fire_s) begin
            sound_r   <= 1'b1;
            secs_r    <= ALARM_SECS_V;
`ifdef ALARM_SNOOZE_EN
            snz_act_r <= 1'b0;
`endif
        end else if (sec_tick_r) begin
            if (sound_r) begin
                if (secs_r <= 8'd1) begin
                    sound_r <= 1'b0;
                    secs_r  <= 8'd0;
                end else begin
                    secs_r  <= secs_r - 8'd1;
                end
            end else begin
                secs_r <= secs_r;
            end
`ifdef ALARM_SNOOZE_EN
            // Sounding and snooze-pending are mutually exclusive, so these never collide.
            if (snz_act_r) begin
                if (snz_cnt_r <= 16'd1) begin
                    snz_act_r <= 1'b0;
                    snz_cnt_r <= 16'd0;
                    sound_r   <= 1'b1;
                    secs_r    <= ALARM_SECS_V;
                end else begin
                    snz_cnt_r <= snz_cnt_r - 16'd1;
                end
            end else begin
                snz_cnt_r <= snz_cnt_r;
            end
`endif
        end else begin
            sound_r <= sound_r;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_seg
        bcd_seg7 u_seg (
            .bcd (disp_s[4*gi +: 4]),
            .seg (seg_s[gi])
        );
    end

    // Registered HEX drivers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                hex_r[i] <= SEG_0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                hex_r[i] <= seg_s[i];
            end
        end
    end

    assign time_bcd    = {hh_r, mm_r, ss_r, cc_r};
    assign alarm_bcd   = {al_hh_r, al_mm_r, al_ss_r, al_cc_r};
    assign tick        = tick_r;
    assign set_err     = set_err_r;
    assign alarm_sound = sound_r;
    assign hex7        = hex_r[7];
    assign hex6        = hex_r[6];
    assign hex5        = hex_r[5];
    assign hex4        = hex_r[4];
    assign hex3        = hex_r[3];
    assign hex2        = hex_r[2];
    assign hex1        = hex_r[1];
    assign hex0        = hex_r[0];

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// Self-checking bench for bcd_alarm_clock at CLK_HZ=1000 (one tick every 10 cycles).
module tb_bcd_alarm_clock;
    import clock_pkg::*;

    localparam int CLK_HZ       = 1000;
    localparam int TICK_HZ      = 100;
    localparam int ALARM_SECS   = 3;
    localparam int SNOOZE_S     = 2;
    localparam int CYC_PER_TICK = CLK_HZ / TICK_HZ;
    localparam int CYC_PER_SEC  = CYC_PER_TICK * 100;
    localparam int DAY_HS       = 24 * 60 * 60 * 100;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  time_in = 8'h00;
    logic [1:0]  set_sel = 2'd0;
    logic        set_time = 1'b0, set_alarm = 1'b0, alarm_en = 1'b0;
    logic        alarm_ack = 1'b0, alarm_snooze = 1'b0, show_alarm = 1'b0;
    logic [31:0] time_bcd, alarm_bcd;
    logic        tick, set_err, alarm_sound;
    logic [6:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
    logic [6:0]  hx [8];

    assign hx[7] = hex7; assign hx[6] = hex6; assign hx[5] = hex5; assign hx[4] = hex4;
    assign hx[3] = hex3; assign hx[2] = hex2; assign hx[1] = hex1; assign hx[0] = hex0;

    bcd_alarm_clock #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ALARM_SECS(ALARM_SECS), .SNOOZE_S(SNOOZE_S)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .time_in(time_in), .set_sel(set_sel),
        .set_time(set_time), .set_alarm(set_alarm), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .alarm_snooze(alarm_snooze), .show_alarm(show_alarm), .time_bcd(time_bcd),
        .alarm_bcd(alarm_bcd), .tick(tick), .set_err(set_err), .alarm_sound(alarm_sound),
        .hex7(hex7), .hex6(hex6), .hex5(hex5), .hex4(hex4),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_pass = 0;
    int n_checks = 0;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] val;
        logic       err;
        logic       both;
    } wvec_t;

    wvec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] val, input logic t, input logic a);
        set_sel = sel; time_in = val; set_time = t; set_alarm = a;
        step();
        set_time = 1'b0; set_alarm = 1'b0;
    endtask

    task automatic set_clock(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
        wr(SEL_HH, h, 1'b1, 1'b0);
        wr(SEL_MM, m, 1'b1, 1'b0);
        wr(SEL_SS, s, 1'b1, 1'b0);
        wr(SEL_CC, c, 1'b1, 1'b0);
    endtask

    function automatic logic [7:0] bcd8(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Reference: hundredths since midnight rendered as BCD fields.
    function automatic logic [31:0] hs_to_bcd(input int hs);
        int t;
        t = hs % DAY_HS;
        return {bcd8(t / 360000), bcd8((t / 6000) % 60), bcd8((t / 100) % 60), bcd8(t % 100)};
    endfunction

    initial begin
        logic [7:0] ef [4];
        logic [7:0] af [4];
        int h, m, s, c, hs, k, ticks, first_tick, edge_s;

        vecs[0]  = '{SEL_SS, 8'h60, 1'b1, 1'b0};
        vecs[1]  = '{SEL_CC, 8'h9A, 1'b1, 1'b0};
        vecs[2]  = '{SEL_HH, 8'h24, 1'b1, 1'b0};
        vecs[3]  = '{SEL_MM, 8'h5A, 1'b1, 1'b0};
        vecs[4]  = '{SEL_HH, 8'hA0, 1'b1, 1'b1};
        vecs[5]  = '{SEL_HH, 8'h23, 1'b0, 1'b0};
        vecs[6]  = '{SEL_MM, 8'h45, 1'b0, 1'b1};
        vecs[7]  = '{SEL_SS, 8'h59, 1'b0, 1'b0};
        vecs[8]  = '{SEL_CC, 8'h99, 1'b0, 1'b0};
        vecs[9]  = '{SEL_MM, 8'h60, 1'b1, 1'b1};
        vecs[10] = '{SEL_SS, 8'h07, 1'b0, 1'b1};
        vecs[11] = '{SEL_CC, 8'h9F, 1'b1, 1'b0};

        // Reset in the middle of counting.
        repeat (3) step();
        reset_n = 1'b1;
        repeat (25) step();
        reset_n = 1'b0;
        #2;
        check("rst_time", time_bcd, 32'h0);
        check("rst_alarm", alarm_bcd, 32'h0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_set_err", {31'd0, set_err}, 32'd0);
        check("rst_sound", {31'd0, alarm_sound}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_hex%0d", i), {25'd0, hx[i]}, 32'h40);
        step();
        reset_n = 1'b1;
        step();

        // Midnight rollover over two ticks.
        set_clock(8'h23, 8'h59, 8'h59, 8'h98);
        check("wrap_loaded", time_bcd, 32'h23595998);
        ticks = 0; first_tick = -1;
        for (int st = 1; st <= 2 * CYC_PER_TICK; st++) begin
            step();
            if (tick) begin
                ticks++;
                if (first_tick < 0) first_tick = st;
            end
            if (st == CYC_PER_TICK) check("wrap_mid", time_bcd, 32'h23595999);
        end
        check("wrap_time", time_bcd, 32'h0);
        check("wrap_tick_count", ticks, 32'd2);
        check("wrap_first_tick", first_tick, CYC_PER_TICK);

        // Write-vector table: valid writes land, invalid ones pulse set_err and change nothing.
        for (int i = 0; i < 4; i++) begin ef[i] = 8'h00; af[i] = 8'h00; end
        for (int i = 0; i < 12; i++) begin
            wr(SEL_CC, 8'h00, 1'b1, 1'b0);
            ef[3] = 8'h00;
            wr(vecs[i].sel, vecs[i].val, 1'b1, vecs[i].both);
            if (!vecs[i].err) begin
                ef[vecs[i].sel] = vecs[i].val;
                if (vecs[i].both) af[vecs[i].sel] = vecs[i].val;
            end
            check($sformatf("vec%0d_set_err", i), {31'd0, set_err}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_time", i), time_bcd, {ef[0], ef[1], ef[2], ef[3]});
            check($sformatf("vec%0d_alarm", i), alarm_bcd, {af[0], af[1], af[2], af[3]});
            step();
            check($sformatf("vec%0d_err_pulse", i), {31'd0, set_err}, 32'd0);
        end

        // Random start times against the arithmetic reference.
        for (int i = 0; i < 10; i++) begin
            h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
            c = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0) begin h = 23; m = 59; s = 59; end
            hs = ((h * 60 + m) * 60 + s) * 100 + c;
            set_clock(bcd8(h), bcd8(m), bcd8(s), bcd8(c));
            check($sformatf("rnd%0d_load", i), time_bcd, hs_to_bcd(hs));
            k = $urandom_range(1, 400);
            repeat (k) step();
            check($sformatf("rnd%0d_run", i), time_bcd, hs_to_bcd(hs + k / CYC_PER_TICK));
        end

        // Alarm setpoint and display of it.
        wr(SEL_HH, 8'h07, 1'b0, 1'b1);
        wr(SEL_MM, 8'h00, 1'b0, 1'b1);
        wr(SEL_SS, 8'h00, 1'b0, 1'b1);
        wr(SEL_CC, 8'h00, 1'b0, 1'b1);
        check("alarm_set", alarm_bcd, 32'h07000000);
        show_alarm = 1'b1;
        step(); step();
        check("disp_hex7", {25'd0, hex7}, 32'h40);
        check("disp_hex6", {25'd0, hex6}, 32'h78);
        check("disp_hex0", {25'd0, hex0}, 32'h40);
        show_alarm = 1'b0;

        // Fire and timeout.
        alarm_en = 1'b1;
        set_clock(8'h06, 8'h59, 8'h59, 8'h99);
        edge_s = -1;
        for (int st = 1; st <= 4000; st++) begin
            step();
            if (st == CYC_PER_TICK) begin
                check("fire_pre", {31'd0, alarm_sound}, 32'd0);
                check("fire_time", time_bcd, 32'h07000000);
            end
            if (st == CYC_PER_TICK + 1) check("fire_rise", {31'd0, alarm_sound}, 32'd1);
            if (st > CYC_PER_TICK + 1 && !alarm_sound) begin edge_s = st; break; end
        end
        check("timeout_cycle", edge_s, CYC_PER_TICK + 1 + ALARM_SECS * CYC_PER_SEC);

        // Acknowledge five cycles into the alarm.
        set_clock(8'h06, 8'h59, 8'h59, 8'h99);
        repeat (CYC_PER_TICK + 5) step();
        check("ack_before", {31'd0, alarm_sound}, 32'd1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("ack_after", {31'd0, alarm_sound}, 32'd0);
        repeat (50) step();
        check("ack_stays_low", {31'd0, alarm_sound}, 32'd0);

        // Acknowledge in the cycle the fire is decided.
        set_clock(8'h06, 8'h59, 8'h59, 8'h99);
        repeat (CYC_PER_TICK) step();
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("ack_beats_fire", {31'd0, alarm_sound}, 32'd0);

        // Snooze behaviour, then disarm.
        set_clock(8'h06, 8'h59, 8'h59, 8'h99);
        repeat (CYC_PER_TICK + 3) step();
        check("snz_sounding", {31'd0, alarm_sound}, 32'd1);
        alarm_snooze = 1'b1;
        step();
        alarm_snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check("snz_silenced", {31'd0, alarm_sound}, 32'd0);
        edge_s = -1;
        for (int st = CYC_PER_TICK + 5; st <= 4000; st++) begin
            step();
            if (alarm_sound) begin edge_s = st; break; end
        end
        check("snz_rise_cycle", edge_s, CYC_PER_TICK + 1 + SNOOZE_S * CYC_PER_SEC);
`else
        check("snz_ignored", {31'd0, alarm_sound}, 32'd1);
`endif
        alarm_en = 1'b0;
        step();
        check("disarm_low", {31'd0, alarm_sound}, 32'd0);

        // Write on the cycle a tick is due: tick dropped, phase restarts.
        set_clock(8'h12, 8'h34, 8'h00, 8'h10);
        repeat (CYC_PER_TICK - 1) step();
        wr(SEL_SS, 8'h33, 1'b1, 1'b0);
        check("due_no_tick", {31'd0, tick}, 32'd0);
        check("due_time", time_bcd, 32'h12343310);
        edge_s = -1;
        for (int st = 1; st <= 30; st++) begin
            step();
            if (tick) begin edge_s = st; break; end
        end
        check("due_next_tick", edge_s, CYC_PER_TICK);
        check("due_after", time_bcd, 32'h12343311);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
